// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrated mux with a one-deep registered output and valid/ready on every port.
// Define RR_ARB_MUX_FIXED_PRI_EN to build fixed lowest-index-wins priority instead of round-robin.
module rr_arb_mux #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_p1, state_nxt;
  logic [WIDTH-1:0]   data_p1;
  logic [SEL_W-1:0]   chan_p1;
  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   gnt;
  logic               gnt_vld;
  logic [WIDTH-1:0]   sel_data;
  logic               can_load;
  logic               accept;

`ifdef RR_ARB_MUX_FIXED_PRI_EN
  assign start = '0;
`else
  logic [SEL_W-1:0] ptr_p1;

  assign start = ptr_p1;

  // Pointer moves one past the winner; explicit wrap keeps non-power-of-2 counts legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_p1 <= '0;
    end else if (accept) begin
      ptr_p1 <= (gnt == SEL_W'(CHANNELS - 1)) ? '0 : gnt + SEL_W'(1);
    end
  end
`endif

  // Scan from the far end back to start so the nearest valid channel is the last one written.
  always_comb begin
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (SEL_W + 1)'(k);
      if (sum >= (SEL_W + 1)'(CHANNELS)) begin
        sum = sum - (SEL_W + 1)'(CHANNELS);
      end
      idx = sum[SEL_W-1:0];
      if (in_valid[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == gnt) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign can_load = (state_p1 == EMPTY) | out_ready;

  always_comb begin
    in_ready = '0;
    if (rst_n && can_load && gnt_vld) begin
      in_ready[gnt] = 1'b1;
    end
  end

  assign accept = |(in_valid & in_ready);

  // ---- output register stage (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (out_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      chan_p1 <= '0;
    end else if (accept) begin
      data_p1 <= sel_data;
      chan_p1 <= gnt;
    end
  end

  always_comb begin
    out_valid = (state_p1 == FULL);
    out_data  = data_p1;
    out_chan  = chan_p1;
  end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel, WIDTH-bit arbitrated multiplexer with a registered output stage and valid/ready handshaking on every port. It generalises the fixed 2:1 and 4:1 select muxes to any channel count. It also replaces the external select with an internal round-robin arbiter, so several MaxNet processing elements can share one downstream consumer without starvation. Output latency is one cycle, and back-to-back transfers run at full rate.

## Interface
- WIDTH, 5, data bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), width of channel index (derived; do not override).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready. One-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

## Operation
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when out_ready=1 and there is no accept.
  - FULL stays FULL when out_ready=0, or when out_ready=1 with an accept.
- can_load = ~out_valid | out_ready.
- Arbitration:
  - grant = first channel with in_valid=1, searching ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1.
  - No grant if in_valid is all zero.
- in_ready[g] = 1 only for the granted channel g, and only when can_load=1. All other bits are 0.
- Accept = any in_valid[i] & in_ready[i]. On accept:
  - out_data <= in_data[g].
  - out_chan <= g.
  - out_valid <= 1.
  - ptr <= (g == CHANNELS-1) ? 0 : g+1. Wrap is explicit, so non-power-of-2 CHANNELS is legal.
- No accept: ptr holds.
- Stall (out_valid=1, out_ready=0): out_data and out_chan hold stable, and in_ready is all zero.
- The arbiter does not lock onto a channel. A channel that drops in_valid before it is granted loses nothing and is not penalised.
- in_ready is combinational from in_valid, ptr, out_valid and out_ready. There is no path from in_data.

## Timing
- Reset values (asynchronous):
  - out_valid=0.
  - out_data=0.
  - out_chan=0.
  - ptr=0.
  - in_ready=0 while rst_n=0.
- Latency is one cycle: data accepted at edge k appears on out_data after edge k.
- Throughput is one transfer per cycle while out_ready=1.
- Simultaneous drain and load in FULL with out_ready=1: the new word replaces the old one at the same edge, with no bubble.
- Reset asserted mid-transfer: the pending output word is discarded, and ptr returns to 0 immediately, without waiting for a clock edge.
- First edge after rst_n deasserts: a normal arbitration cycle.

## Configuration
- RR_ARB_MUX_FIXED_PRI_EN:
  - Defined: fixed-priority arbitration. The lowest-index valid channel always wins. The ptr register and its update logic are not built, and out_chan still reports the winner.
  - Undefined (default): round-robin as above.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data and out_chan go to 0 without a clock edge; the first grant after release goes to channel 0 when all channels are valid.
- Rotation: CHANNELS=4, all in_valid=1, in_data={4,3,2,1}, out_ready=1 -> out_chan sequence 0,1,2,3,0 with out_data 1,2,3,4,1 on consecutive cycles, and exactly one in_ready high each cycle.
- Skip and wrap: CHANNELS=3, only channels 0 and 2 valid, ptr=1 -> grant 2, then 0, then 2; no cycle grants channel 1.
- Backpressure: out_valid=1 holding data 7 on channel 1, out_ready=0 for 3 cycles -> out_data=7 and out_chan=1 stable, in_ready all 0, ptr unchanged; when out_ready=1, the next word loads on the same edge.
- Sparse input: single pulse in_valid[3]=1 with data 21, then idle -> out_valid high for exactly one cycle with out_chan=3, then EMPTY.
- Fixed-priority build with RR_ARB_MUX_FIXED_PRI_EN, all channels valid, out_ready=1 -> out_chan=0 every cycle, and channels 1..3 never receive in_ready.
